// File: rtl/arb_4req_ctrl_if.sv
// Request/grant bundle between the four requesters and arb_4req_ctrl.
// master: requester side; slave: arbiter side.
interface arb_4req_ctrl_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, timeout
  );
endinterface

// File: rtl/arb_4req_ctrl.sv
// Four-way arbiter with registered one-hot grant and a contended hold budget.
// Define ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority, req[3] highest.
module arb_4req_ctrl #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  arb_4req_ctrl_if.slave  bus
);

  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    id_q, id_d;
  logic          to_q, to_d;
  logic [1:0]    win;
  logic          rel_done, rel_drop, rel_hold;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;
  logic [1:0] cand;
  logic       found;

  // Search downward from last_id-1; last_id itself is examined last.
  always_comb begin
    win   = last_q;
    cand  = last_q;
    found = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_q - 2'(i);
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = 2'd0;
    if (bus.req[3])      win = 2'd3;
    else if (bus.req[2]) win = 2'd2;
    else if (bus.req[1]) win = 2'd1;
  end
`endif

  // gnt_q is one-hot on the owner while in GRANT, so it doubles as the owner mask.
  assign rel_done = bus.done;
  assign rel_drop = ~|(bus.req & gnt_q);
  assign rel_hold = (hold_q == HOLD_LAST) && (|(bus.req & ~gnt_q));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    to_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|bus.req) begin
          gnt_d   = 4'b0001 << win;
          id_d    = win;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_hold) begin
          gnt_d   = '0;
          hold_d  = '0;
          to_d    = rel_hold && !rel_done && !rel_drop;
          state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = id_q;
`endif
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      to_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      to_q    <= to_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.busy    = (state_q == GRANT);
  assign bus.timeout = to_q;

endmodule

// File: tb/tb_arb_4req_ctrl.sv
// Bench for arb_4req_ctrl (MAX_HOLD=4): directed vector table, hand-written
// corner sequences, then random traffic against a behavioural model.
module tb_arb_4req_ctrl;

  localparam int MAX_HOLD = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst;
  arb_4req_ctrl_if bus ();

  arb_4req_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Behavioural model: owner index (-1 = none), gnt-high cycles so far.
  int m_owner = -1;
  int m_held  = 0;
  bit m_to    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
  int m_last  = 0;
`endif

  function automatic int pick(input logic [3:0] r);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_last - k + 8) % 4;
      if (r[c[1:0]]) return c;
    end
`else
    for (int c = 3; c >= 0; c--)
      if (r[c[1:0]]) return c;
`endif
    return -1;
  endfunction

  function automatic logic [3:0] m_gnt();
    if (m_owner < 0) return 4'b0000;
    return 4'(1 << m_owner);
  endfunction

  task automatic model_step(input bit r, input logic [3:0] q, input bit d);
    bit a, b, c;
    if (r) begin
      m_owner = -1;
      m_held  = 0;
      m_to    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      m_last  = 0;
`endif
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (q != 4'b0000) begin
        m_owner = pick(q);
        m_held  = 1;
      end
    end else begin
      a = d;
      b = !q[m_owner[1:0]];
      c = (m_held >= MAX_HOLD) && ((q & ~m_gnt()) != 4'b0000);
      if (a || b || c) begin
        m_to = c && !a && !b;
`ifdef ARB_ROUND_ROBIN_EN
        m_last = m_owner;
`endif
        m_owner = -1;
      end else begin
        m_held++;
        m_to = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive inputs, clock once, advance the model, sample 1 ns after the edge.
  task automatic tick(input bit r, input logic [3:0] q, input bit d);
    rst      = r;
    bus.req  = q;
    bus.done = d;
    @(posedge clk);
    model_step(r, q, d);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input bit busy, input bit to, input bit cid);
    check({tag, ".gnt"}, 8'(bus.gnt), 8'(g));
    check({tag, ".busy"}, 8'(bus.busy), 8'(busy));
    check({tag, ".timeout"}, 8'(bus.timeout), 8'(to));
    if (cid) check({tag, ".gnt_id"}, 8'(bus.gnt_id), 8'(id));
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] req;
    bit         done;
    logic [3:0] gnt;
    logic [1:0] id;
    bit         busy;
    bit         to;
    bit         cid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input logic [3:0] q, input bit d, input logic [3:0] g,
                     input logic [1:0] id, input bit busy, input bit to, input bit cid);
    vec_t v;
    v = '{rst: r, req: q, done: d, gnt: g, id: id, busy: busy, to: to, cid: cid};
    tbl.push_back(v);
  endtask

  logic [1:0] rot_id [4];
  logic [3:0] rq;

  initial begin
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;

    // Reset, 0101 grant, done release, re-arbitration.
    add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 1);
    add(1, 4'b0101, 0, 4'b0000, 2'd0, 0, 0, 1);
    add(0, 4'b0101, 0, 4'b0100, 2'd2, 1, 0, 1);
    add(0, 4'b0101, 1, 4'b0000, 2'd0, 0, 0, 0);
    add(0, 4'b0101, 0, RR ? 4'b0001 : 4'b0100, RR ? 2'd0 : 2'd2, 1, 0, 1);
    add(0, 4'b0101, 1, 4'b0000, 2'd0, 0, 0, 0);
    // Hold budget: 1001 held, four grant cycles, timeout with the drop.
    add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 1);
    for (int i = 0; i < MAX_HOLD; i++)
      add(0, 4'b1001, 0, 4'b1000, 2'd3, 1, 0, 1);
    add(0, 4'b1001, 0, 4'b0000, 2'd0, 0, 1, 0);
    add(0, 4'b1001, 0, RR ? 4'b0001 : 4'b1000, RR ? 2'd0 : 2'd3, 1, 0, 1);
    add(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, 0);

    foreach (tbl[i]) begin
      tick(tbl[i].rst, tbl[i].req, tbl[i].done);
      expect_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].busy, tbl[i].to, tbl[i].cid);
    end

    // Single uncontended requester keeps the grant with no timeout.
    for (int i = 0; i < 20; i++) begin
      tick(0, 4'b0010, 0);
      expect_out("solo", 4'b0010, 2'd1, 1, 0, 1);
    end
    // Contention arriving after the counter saturated preempts at once.
    tick(0, 4'b0011, 0);
    expect_out("late_contend", 4'b0000, 2'd0, 0, 1, 0);

    // done + drop + exhausted budget on one edge: single release, no timeout.
    tick(0, 4'b0010, 0);
    expect_out("sim_grant", 4'b0010, 2'd1, 1, 0, 1);
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      tick(0, 4'b0010, 0);
      expect_out("sim_hold", 4'b0010, 2'd1, 1, 0, 1);
    end
    tick(0, 4'b1000, 1);
    expect_out("sim_rel", 4'b0000, 2'd0, 0, 0, 0);
    tick(0, 4'b1000, 0);
    expect_out("sim_next", 4'b1000, 2'd3, 1, 0, 1);

    // Reset on the third grant cycle.
    tick(0, 4'b1111, 0);
    expect_out("rst_g2", 4'b1000, 2'd3, 1, 0, 1);
    tick(0, 4'b1111, 0);
    expect_out("rst_g3", 4'b1000, 2'd3, 1, 0, 1);
    tick(1, 4'b1111, 0);
    expect_out("rst_mid", 4'b0000, 2'd0, 0, 0, 1);
    tick(0, 4'b1111, 0);
    expect_out("rst_after", 4'b1000, 2'd3, 1, 0, 1);

    // All four requesting, done on every grant cycle.
    rot_id = RR ? '{2'd2, 2'd1, 2'd0, 2'd3} : '{2'd3, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 4; i++) begin
      tick(0, 4'b1111, 1);
      expect_out("rot_idle", 4'b0000, 2'd0, 0, 0, 0);
      tick(0, 4'b1111, 0);
      expect_out($sformatf("rot%0d", i), 4'(1 << rot_id[i]), rot_id[i], 1, 0, 1);
    end

    // Random traffic against the model.
    rq = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      bit r, d;
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 99) == 0);
      d = ($urandom_range(0, 5) == 0);
      tick(r, rq, d);
      check("rnd.gnt", 8'(bus.gnt), 8'(m_gnt()));
      check("rnd.busy", 8'(bus.busy), 8'(m_owner >= 0));
      check("rnd.timeout", 8'(bus.timeout), 8'(m_to));
      if (m_owner >= 0) check("rnd.gnt_id", 8'(bus.gnt_id), 8'(m_owner));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
